// File: rtl/risc16_pkg.sv
// risc16_pkg: shared definitions for the Risc16 single-cycle processor.
//   - opcode encodings (OP_LD .. OP_JMP)
//   - instruction field bit positions
//   - ALU operation enum
//   - sign-extension helper for the 6-bit offset field
package risc16_pkg;

  localparam int XLEN = 16;

  // Opcode encodings (instr[15:12]); 1010, 1110 and 1111 decode as NOP.
  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_INV = 4'b0100;
  localparam logic [3:0] OP_LSL = 4'b0101;
  localparam logic [3:0] OP_LSR = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;

  // Instruction field positions.
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RS1_HI = 11;
  localparam int RS1_LO = 9;
  localparam int RS2_HI = 8;
  localparam int RS2_LO = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 3;
  localparam int OFF_HI = 5;
  localparam int OFF_LO = 0;
  localparam int JMP_HI = 11;
  localparam int JMP_LO = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_INV = 3'd2,
    ALU_LSL = 3'd3,
    ALU_LSR = 3'd4,
    ALU_AND = 3'd5,
    ALU_OR  = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  function automatic logic [XLEN-1:0] sext6(input logic [5:0] off);
    return {{(XLEN-6){off[5]}}, off};
  endfunction

endpackage

// File: rtl/risc16_alu.sv
// risc16_alu: purely combinational 16-bit ALU.
// Ports:
//   a, b    in  16  operands (b is the register or the sign-extended offset)
//   alu_op  in   3  operation select (alu_op_e)
//   result  out 16  operation result
//   zero    out  1  result == 0; with ALU_SUB this is the equality test for branches
module risc16_alu
  import risc16_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         alu_op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_INV: result = ~a;
      // Shift amount is the full 16-bit operand: anything above 15 clears the word.
      ALU_LSL: result = (b > 16'd15) ? '0 : (a << b[3:0]);
      ALU_LSR: result = (b > 16'd15) ? '0 : (a >> b[3:0]);
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = (a < b) ? 16'd1 : 16'd0;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/risc16_cpu.sv
// risc16_cpu: single-cycle 16-bit RISC processor. Fetch, decode, execute,
// memory access and writeback all complete within one clock. Holds its own
// instruction ROM, data RAM and 8x16 register file; runs from clk/rst_n only.
// Ports:
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset (pc and registers to 0)
//   pc_o        out 16  current program counter (byte address)
//   instr_o     out 16  instruction executing this cycle
//   rf_we_o     out  1  register-file write enable this cycle
//   rf_waddr_o  out  3  register write address
//   rf_wdata_o  out 16  register write data
//   dm_we_o     out  1  data-memory write enable this cycle
module risc16_cpu
  import risc16_pkg::*;
#(
  parameter string IMEM_FILE  = "test.prog",
  parameter string DMEM_FILE  = "test.data",
  parameter int    IMEM_DEPTH = 16,
  parameter int    DMEM_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            rf_we_o,
  output logic [2:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            dm_we_o
);

  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] regs [8];

  logic [XLEN-1:0] pc, pc2, pc_next, br_target, jmp_target;
  logic [XLEN-1:0] instr, imm;
  logic [3:0]      op;
  logic [2:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_res, ld_data;
  logic            alu_zero;
  alu_op_e         alu_op;
  logic            use_imm;
  logic            rf_we, dm_we;
  logic [2:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  // Fetch: pc is a byte address, so word index is pc[4:1] and wraps in 16 words.
  assign instr = imem[pc[4:1]];

  assign op  = instr[OP_HI:OP_LO];
  assign rs1 = instr[RS1_HI:RS1_LO];
  assign rs2 = instr[RS2_HI:RS2_LO];
  assign rd  = instr[RD_HI:RD_LO];
  assign imm = sext6(instr[OFF_HI:OFF_LO]);

  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];

  assign pc2        = pc + 16'd2;
  assign br_target  = pc2 + {imm[XLEN-2:0], 1'b0};
  assign jmp_target = {pc2[15:13], instr[JMP_HI:JMP_LO], 1'b0};

  // ALU control depends on the opcode only; kept apart from the writeback
  // and pc selection below so no combinational block reads its own output.
  always_comb begin
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    case (op)
      OP_LD, OP_ST:   use_imm = 1'b1;
      OP_SUB:         alu_op  = ALU_SUB;
      OP_INV:         alu_op  = ALU_INV;
      OP_LSL:         alu_op  = ALU_LSL;
      OP_LSR:         alu_op  = ALU_LSR;
      OP_AND:         alu_op  = ALU_AND;
      OP_OR:          alu_op  = ALU_OR;
      OP_SLT:         alu_op  = ALU_SLT;
      OP_BEQ, OP_BNE: alu_op  = ALU_SUB;
      default:        alu_op  = ALU_ADD;
    endcase
  end

  assign alu_b = use_imm ? imm : rs2_val;

  risc16_alu u_alu (
    .a      (rs1_val),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // For LD/ST the ALU result is the effective address; only [2:0] selects a word.
  assign ld_data = dmem[alu_res[2:0]];

  // Writeback and next-pc selection. At most one of rf_we/dm_we is set.
  always_comb begin
    rf_we    = 1'b0;
    dm_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = alu_res;
    pc_next  = pc2;
    case (op)
      OP_LD: begin
        rf_we    = 1'b1;
        rf_waddr = rs2;
        rf_wdata = ld_data;
      end
      OP_ST: dm_we = 1'b1;
      OP_ADD, OP_SUB, OP_INV, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_SLT: rf_we = 1'b1;
      OP_BEQ: if (alu_zero)  pc_next = br_target;
      OP_BNE: if (!alu_zero) pc_next = br_target;
      OP_JMP: pc_next = jmp_target;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= pc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Data RAM is not cleared by reset, but an edge seen while reset is held
  // must not commit a store.
  always_ff @(posedge clk) begin
    if (rst_n && dm_we) dmem[alu_res[2:0]] <= rs2_val;
  end

  assign pc_o       = pc;
  assign instr_o    = instr;
  assign rf_we_o    = rf_we;
  assign rf_waddr_o = rf_waddr;
  assign rf_wdata_o = rf_wdata;
  assign dm_we_o    = dm_we;

endmodule

// File: tb/tb_risc16_cpu.sv
// tb_risc16_cpu: directed programs loaded into the core's memories; each
// executed instruction's expected observation is queued and a negedge
// monitor pops and compares it against the observation ports.
module tb_risc16_cpu;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_o;
  logic [15:0] instr_o;
  logic        rf_we_o;
  logic [2:0]  rf_waddr_o;
  logic [15:0] rf_wdata_o;
  logic        dm_we_o;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic        rf_we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        dm_we;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  risc16_cpu #(
    .IMEM_FILE  (""),
    .DMEM_FILE  (""),
    .IMEM_DEPTH (16),
    .DMEM_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_o       (pc_o),
    .instr_o    (instr_o),
    .rf_we_o    (rf_we_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .dm_we_o    (dm_we_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- programs ----------------
  logic [15:0] prog_a [16];
  logic [15:0] prog_b [16];

  initial begin
    prog_a = '{16'h0400, 16'h0441, 16'h2050, 16'h3058, 16'h4020, 16'hB002, 16'hC005, 16'hB03F,
               16'h5068, 16'h6230, 16'h7078, 16'h8078, 16'h9078, 16'h9238, 16'hA000, 16'hD006};
    prog_b = '{16'h0400, 16'h0441, 16'h2050, 16'h1A82, 16'h0AC2, 16'h0B09, 16'h123F, 16'h0B41,
               16'hCA42, 16'hE000, 16'hF000, 16'h2A70, 16'hB03F, 16'hE000, 16'hE000, 16'hE000};
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_imem(input int which);
    for (int i = 0; i < 16; i++) dut.imem[i] = (which == 0) ? prog_a[i] : prog_b[i];
  endtask

  task automatic load_dmem();
    for (int i = 0; i < 8; i++) dut.dmem[i] = 16'h0000;
    dut.dmem[0] = 16'h0001;
    dut.dmem[1] = 16'h0002;
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr, input logic we,
                      input logic [2:0] waddr, input logic [15:0] wdata, input logic dm);
    exp_t e;
    e.pc = pc; e.instr = instr; e.rf_we = we; e.waddr = waddr; e.wdata = wdata; e.dm_we = dm;
    exp_q.push_back(e);
  endtask

  task automatic push_prog_a();
    push(16'h00, 16'h0400, 1, 3'd0, 16'h0001, 0);  // LD r0,0(r2)
    push(16'h02, 16'h0441, 1, 3'd1, 16'h0002, 0);  // LD r1,1(r2)
    push(16'h04, 16'h2050, 1, 3'd2, 16'h0003, 0);  // ADD r2,r0,r1
    push(16'h06, 16'h3058, 1, 3'd3, 16'hFFFF, 0);  // SUB r3,r0,r1
    push(16'h08, 16'h4020, 1, 3'd4, 16'hFFFE, 0);  // INV r4,r0
    push(16'h0A, 16'hB002, 0, 3'd0, 16'h0000, 0);  // BEQ r0,r0,+2 taken -> 0x10
    push(16'h10, 16'h5068, 1, 3'd5, 16'h0004, 0);  // LSL r5,r0,r1
    push(16'h12, 16'h6230, 1, 3'd6, 16'h0001, 0);  // LSR r6,r1,r0
    push(16'h14, 16'h7078, 1, 3'd7, 16'h0000, 0);  // AND r7,r0,r1
    push(16'h16, 16'h8078, 1, 3'd7, 16'h0003, 0);  // OR  r7,r0,r1
    push(16'h18, 16'h9078, 1, 3'd7, 16'h0001, 0);  // SLT r7,r0,r1
    push(16'h1A, 16'h9238, 1, 3'd7, 16'h0000, 0);  // SLT r7,r1,r0
    push(16'h1C, 16'hA000, 0, 3'd0, 16'h0000, 0);  // NOP
    push(16'h1E, 16'hD006, 0, 3'd0, 16'h0000, 0);  // JMP 0x006 -> 0x0C
    push(16'h0C, 16'hC005, 0, 3'd0, 16'h0000, 0);  // BNE r0,r0 not taken
    for (int i = 0; i < 3; i++)
      push(16'h0E, 16'hB03F, 0, 3'd0, 16'h0000, 0);  // halt: BEQ r0,r0,-1
  endtask

  task automatic push_prog_b(input int count);
    exp_t t[14];
    t[0]  = {16'h00, 16'h0400, 1'b1, 3'd0, 16'h0001, 1'b0};  // LD r0,0(r2)
    t[1]  = {16'h02, 16'h0441, 1'b1, 3'd1, 16'h0002, 1'b0};  // LD r1,1(r2)
    t[2]  = {16'h04, 16'h2050, 1'b1, 3'd2, 16'h0003, 1'b0};  // ADD r2,r0,r1
    t[3]  = {16'h06, 16'h1A82, 1'b0, 3'd0, 16'h0000, 1'b1};  // ST r2,2(r5)
    t[4]  = {16'h08, 16'h0AC2, 1'b1, 3'd3, 16'h0003, 1'b0};  // LD r3,2(r5): stored value
    t[5]  = {16'h0A, 16'h0B09, 1'b1, 3'd4, 16'h0002, 1'b0};  // LD r4,9(r5): aliases word 1
    t[6]  = {16'h0C, 16'h123F, 1'b0, 3'd0, 16'h0000, 1'b1};  // ST r0,-1(r1) -> word 1
    t[7]  = {16'h0E, 16'h0B41, 1'b1, 3'd5, 16'h0001, 1'b0};  // LD r5,1(r5)
    t[8]  = {16'h10, 16'hCA42, 1'b0, 3'd0, 16'h0000, 1'b0};  // BNE r5,r1,+2 taken -> 0x16
    t[9]  = {16'h16, 16'h2A70, 1'b1, 3'd6, 16'h0003, 1'b0};  // ADD r6,r5,r1
    t[10] = {16'h18, 16'hB03F, 1'b0, 3'd0, 16'h0000, 1'b0};  // halt
    t[11] = t[10];
    t[12] = t[10];
    t[13] = t[10];
    for (int i = 0; i < count && i < 14; i++) exp_q.push_back(t[i]);
  endtask

  task automatic wait_drain(input int budget);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc_o", pc_o, e.pc);
      check("instr_o", instr_o, e.instr);
      check("rf_we_o", {15'd0, rf_we_o}, {15'd0, e.rf_we});
      check("dm_we_o", {15'd0, dm_we_o}, {15'd0, e.dm_we});
      if (e.rf_we) begin
        check("rf_waddr_o", {13'd0, rf_waddr_o}, {13'd0, e.waddr});
        check("rf_wdata_o", rf_wdata_o, e.wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    #1;
    load_imem(0);
    load_dmem();

    // Reset held for three edges: pc at 0 and the first word presented.
    repeat (3) @(posedge clk);
    #1;
    check("reset_pc", pc_o, 16'h0000);
    check("reset_instr", instr_o, 16'h0400);

    // Program A: loads, ALU ops, branches, jump, halt.
    push_prog_a();
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_drain(40);

    // Asynchronous reset while halted at a nonzero pc.
    rst_n = 1'b0;
    #1;
    check("async_reset_pc_halt", pc_o, 16'h0000);
    load_imem(1);
    load_dmem();

    // Program B: stores, aliasing, negative offset, taken BNE.
    @(posedge clk);
    @(posedge clk);
    push_prog_b(14);
    #2 rst_n = 1'b1;
    wait_drain(40);

    // Program B again, interrupted by reset while the ADD is executing.
    rst_n = 1'b0;
    load_dmem();
    @(posedge clk);
    @(posedge clk);
    push_prog_b(3);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_pc", pc_o, 16'h0000);
    check("midrun_reset_instr", instr_o, 16'h0400);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL midrun_pending: got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    @(posedge clk);
    // Registers must read back as zero: LD r0,0(r2) has to fetch word 0.
    push_prog_b(14);
    #2 rst_n = 1'b1;
    wait_drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
